// File: rtl/dds_wave_meas.sv
// Waveform analyzer for the DDS/DAC sample bus. It measures the period between
// rising midscale crossings, plus the peak max and min over that period.
module dds_wave_meas #(
    parameter int DATA_W     = 10,
    parameter int MID        = 512,
    parameter int HYST       = 16,
    parameter int PERIOD_W   = 20,
    parameter int MAX_PERIOD = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   sample,
    input  logic                sample_valid,
    output logic [PERIOD_W-1:0] period,
    output logic [DATA_W-1:0]   peak_max,
    output logic [DATA_W-1:0]   peak_min,
    output logic                meas_valid,
    output logic                locked,
    output logic                timeout
);

    localparam logic SEEK_LOW  = 1'b0;
    localparam logic SEEK_HIGH = 1'b1;

    localparam logic [DATA_W-1:0]   LO_TH    = DATA_W'(MID - HYST);
    localparam logic [DATA_W-1:0]   HI_TH    = DATA_W'(MID + HYST);
    localparam logic [PERIOD_W-1:0] CNT_LAST = PERIOD_W'(MAX_PERIOD - 1);

    logic                state;
    logic                have_ref;
    logic [PERIOD_W-1:0] cnt;
    logic [DATA_W-1:0]   run_max;
    logic [DATA_W-1:0]   run_min;
    logic                rc;

    assign rc = (state == SEEK_HIGH) && (sample >= HI_TH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period     <= '0;
            peak_max   <= '0;
            peak_min   <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            state      <= SEEK_LOW;
            have_ref   <= 1'b0;
            cnt        <= '0;
            run_max    <= '0;
            run_min    <= '0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sample_valid) begin
                if (rc) begin
                    // The peaks are taken before this sample, so the window ends just short of the new crossing.
                    if (have_ref) begin
                        period     <= cnt;
                        peak_max   <= run_max;
                        peak_min   <= run_min;
                        meas_valid <= 1'b1;
                        locked     <= 1'b1;
                    end
                    have_ref <= 1'b1;
                    cnt      <= PERIOD_W'(1);
                    run_max  <= sample;
                    run_min  <= sample;
                    state    <= SEEK_LOW;
                end else if (have_ref && cnt == CNT_LAST) begin
                    timeout  <= 1'b1;
                    locked   <= 1'b0;
                    have_ref <= 1'b0;
                    cnt      <= '0;
                    state    <= SEEK_LOW;
                end else begin
                    if (state == SEEK_LOW && sample <= LO_TH)
                        state <= SEEK_HIGH;
                    if (have_ref) begin
                        cnt <= cnt + PERIOD_W'(1);
                        if (sample > run_max)
                            run_max <= sample;
                        if (sample < run_min)
                            run_min <= sample;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_wave_meas.sv
// Bench for dds_wave_meas: scenario table, hand-written timeout and reset
// sequences, and randomized waveforms checked against a window-based model.
module tb_dds_wave_meas;

    localparam int DATA_W   = 10;
    localparam int MID      = 512;
    localparam int HYST     = 16;
    localparam int PERIOD_W = 20;
    localparam int MAXP     = 1000;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [DATA_W-1:0]   sample = '0;
    logic                sample_valid = 1'b0;
    logic [PERIOD_W-1:0] period;
    logic [DATA_W-1:0]   peak_max;
    logic [DATA_W-1:0]   peak_min;
    logic                meas_valid;
    logic                locked;
    logic                timeout;

    dds_wave_meas #(
        .DATA_W(DATA_W), .MID(MID), .HYST(HYST),
        .PERIOD_W(PERIOD_W), .MAX_PERIOD(MAXP)
    ) dut (
        .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
        .period(period), .peak_max(peak_max), .peak_min(peak_min),
        .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: crossing detector plus the list of samples since the last crossing.
    bit                  m_armed;
    bit                  m_ref;
    int                  win[$];
    logic [PERIOD_W-1:0] e_period;
    logic [DATA_W-1:0]   e_max;
    logic [DATA_W-1:0]   e_min;
    logic                e_mv, e_lock, e_to;

    int cyc;
    int seq_idx;
    int mv_at[$];
    int to_cnt;
    int to_idx;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_clear();
        m_armed = 0; m_ref = 0; win.delete();
        e_period = '0; e_max = '0; e_min = '0;
        e_mv = 0; e_lock = 0; e_to = 0;
    endfunction

    task automatic model_accept(input int x);
        int mx, mn;
        if (m_armed && x >= MID + HYST) begin
            if (m_ref) begin
                mx = win[0]; mn = win[0];
                foreach (win[i]) begin
                    if (win[i] > mx) mx = win[i];
                    if (win[i] < mn) mn = win[i];
                end
                e_period = PERIOD_W'(win.size());
                e_max = DATA_W'(mx); e_min = DATA_W'(mn);
                e_mv = 1; e_lock = 1;
            end
            win.delete(); win.push_back(x);
            m_ref = 1; m_armed = 0;
        end else begin
            if (!m_armed && x <= MID - HYST) m_armed = 1;
            if (m_ref) begin
                if (win.size() + 1 == MAXP) begin
                    e_to = 1; e_lock = 0; m_ref = 0; m_armed = 0;
                    win.delete();
                end else begin
                    win.push_back(x);
                end
            end
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return {21'b0, period, peak_max, peak_min, meas_valid, locked, timeout};
    endfunction

    function automatic logic [63:0] exp_vec();
        return {21'b0, e_period, e_max, e_min, e_mv, e_lock, e_to};
    endfunction

    task automatic clr_stats();
        mv_at.delete(); to_cnt = 0; to_idx = -1; seq_idx = 0;
    endtask

    task automatic step(input int s, input bit v);
        sample = DATA_W'(s); sample_valid = v;
        @(posedge clk);
        e_mv = 0; e_to = 0;
        if (v) model_accept(s);
        #1;
        if (meas_valid) mv_at.push_back(cyc);
        if (timeout) begin to_cnt++; to_idx = seq_idx; end
        if (v) seq_idx++;
        chk("cycle_outputs", dut_vec(), exp_vec());
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0; sample_valid = 1'b0;
        #1;
        chk("reset_async", dut_vec(), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        model_clear();
        chk("reset_hold", dut_vec(), 64'd0);
        rst = 1'b1;
        clr_stats();
    endtask

    // kind 0: full-scale sine, 1: half low / half high square, 2: sine of +-amp around MID
    function automatic int wave(input int kind, input int spc, input int amp, input int k);
        real ph;
        int v;
        ph = 2.0 * 3.14159265358979 * real'(k % spc) / real'(spc);
        case (kind)
            0: v = $rtoi(511.5 + 511.5 * $sin(ph) + 0.5);
            1: v = ((k % spc) < spc / 2) ? 0 : 1023;
            default: v = $rtoi(real'(MID) + real'(amp) * $sin(ph) + 0.5);
        endcase
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    typedef struct {
        int kind; int spc; int amp; int k0; int gap; int ncyc;
        int e_pulses; int e_period; int e_max; int e_min;
    } vec_t;

    vec_t vt[3];

    initial begin
        int bad, rsp, ramp, rnz, k, x;
        cyc = 0;
        model_clear();
        clr_stats();

        vt[0] = '{kind: 0, spc: 64, amp: 0,   k0: 48, gap: 1, ncyc: 5,
                  e_pulses: 4, e_period: 64, e_max: 1023, e_min: 0};
        vt[1] = '{kind: 1, spc: 16, amp: 0,   k0: 0,  gap: 2, ncyc: 5,
                  e_pulses: 4, e_period: 16, e_max: 1023, e_min: 0};
        vt[2] = '{kind: 2, spc: 40, amp: 100, k0: 30, gap: 1, ncyc: 5,
                  e_pulses: 4, e_period: 40, e_max: 612,  e_min: 412};

        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int i = 0; i < vt[t].spc * vt[t].ncyc; i++) begin
                step(wave(vt[t].kind, vt[t].spc, vt[t].amp, vt[t].k0 + i), 1'b1);
                for (int g = 1; g < vt[t].gap; g++)
                    step($urandom_range(0, 1023), 1'b0);
            end
            chk("vec_pulses", mv_at.size(), vt[t].e_pulses);
            chk("vec_period", period, vt[t].e_period);
            chk("vec_peak_max", peak_max, vt[t].e_max);
            chk("vec_peak_min", peak_min, vt[t].e_min);
            chk("vec_locked", locked, 1);
            bad = 0;
            for (int i = 1; i < mv_at.size(); i++)
                if (mv_at[i] - mv_at[i-1] != vt[t].spc * vt[t].gap) bad++;
            chk("vec_pulse_spacing", bad, 0);
        end

        // One measured sine period, then in-band noise until the timeout fires
        do_reset();
        for (int i = 0; i < 128; i++) step(wave(0, 64, 0, 48 + i), 1'b1);
        chk("noise_pre_pulses", mv_at.size(), 1);
        chk("noise_pre_locked", locked, 1);
        clr_stats();
        for (int i = 0; i < 2000; i++) step($urandom_range(500, 524), 1'b1);
        chk("noise_pulses", mv_at.size(), 0);
        chk("noise_timeouts", to_cnt, 1);
        chk("noise_locked", locked, 0);
        chk("noise_period_held", period, 64);

        // Constant zero after lock; the last crossing is sample index 24
        do_reset();
        for (int i = 0; i < 32; i++) step(wave(1, 16, 0, i), 1'b1);
        chk("zero_pre_pulses", mv_at.size(), 1);
        for (int i = 0; i < 3000; i++) step(0, 1'b1);
        chk("zero_timeouts", to_cnt, 1);
        chk("zero_timeout_delay", to_idx - 24, MAXP - 1);
        chk("zero_locked", locked, 0);
        chk("zero_period_held", period, 16);

        // Reset in the middle of a sine cycle
        do_reset();
        for (int i = 0; i < 100; i++) step(wave(0, 64, 0, 48 + i), 1'b1);
        chk("rst_pre_locked", locked, 1);
        do_reset();
        for (int i = 0; i < 192; i++) step(wave(0, 64, 0, 148 + i), 1'b1);
        chk("rst_post_pulses", mv_at.size(), 2);
        chk("rst_post_period", period, 64);
        chk("rst_post_locked", locked, 1);

        // Randomized sines with noise, idle cycles, junk and flat stretches
        do_reset();
        for (int r = 0; r < 6; r++) begin
            rsp  = $urandom_range(20, 120);
            ramp = $urandom_range(20, 511);
            rnz  = $urandom_range(0, 40);
            k = 0;
            while (k < rsp * 6) begin
                if ($urandom_range(0, 3) != 0) begin
                    x = wave(2, rsp, ramp, k) + $urandom_range(0, 2 * rnz) - rnz;
                    if (x < 0) x = 0;
                    if (x > 1023) x = 1023;
                    step(x, 1'b1);
                    k++;
                end else begin
                    step($urandom_range(0, 1023), 1'b0);
                end
            end
            if (r % 2 == 0) begin
                for (int i = 0; i < 200; i++)
                    step($urandom_range(0, 1023), $urandom_range(0, 1) == 1);
            end else begin
                x = $urandom_range(0, 1023);
                for (int i = 0; i < 1100; i++) step(x, 1'b1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
